// File: rtl/galaxian_cfg_pkg.sv
// rtl/galaxian_cfg_pkg.sv - stream indices, loader states and game variant indices for the galaxian core
package galaxian_cfg_pkg;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } cfg_state_t;

  localparam int MOD_GALAXIAN  = 0;
  localparam int MOD_MOONCRST  = 1;
  localparam int MOD_MOONQSR   = 2;
  localparam int MOD_SKYBASE   = 3;
  localparam int MOD_BLACKHOLE = 4;
  localparam int MOD_AZURIAN   = 5;
  localparam int MOD_CATACOMB  = 6;
  localparam int MOD_CHEWINGG  = 7;
  localparam int MOD_DEVILFSH  = 8;
  localparam int MOD_KINGBAL   = 9;
  localparam int MOD_MRDONIGH  = 10;
  localparam int MOD_OMEGA     = 11;
  localparam int MOD_ORBITRON  = 12;
  localparam int MOD_PISCES    = 13;
  localparam int MOD_UNIWARS   = 14;
  localparam int MOD_WAROFBUG  = 15;
  localparam int MOD_ZIGZAG    = 16;
  localparam int MOD_LUCKTODAY = 17;

endpackage

// File: rtl/cfg_reset_stretch.sv
// rtl/cfg_reset_stretch.sv - holds the core in reset during a download and for RST_HOLD+1 cycles after it
module cfg_reset_stretch
  import galaxian_cfg_pkg::*;
#(
  parameter int RST_HOLD = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_download,
  output logic o_core_reset
);

  localparam int CW = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD);

  cfg_state_t    r_state;
  cfg_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_core_reset;
  logic          w_core_reset_nxt;

  // Leaving reset goes straight to HOLD so the core starts on a settled configuration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_HOLD;
      r_cnt        <= HOLD_LOAD;
      r_core_reset <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_core_reset <= w_core_reset_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: if (i_download) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (!i_download) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (i_download)           w_state_nxt = ST_LOAD;
        else if (r_cnt == '0)     w_state_nxt = ST_IDLE;
        else                      w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = ST_HOLD;
    endcase
    w_core_reset_nxt = (w_state_nxt != ST_IDLE);
  end

  assign o_core_reset = r_core_reset;

endmodule

// File: rtl/ioctl_cfg_loader.sv
// rtl/ioctl_cfg_loader.sv - routes the ioctl download stream into ROM writes, game select and DIP bank
module ioctl_cfg_loader
  import galaxian_cfg_pkg::*;
#(
  parameter int NUM_MODS  = 18,
  parameter int ROM_AW    = 16,
  parameter int RST_HOLD  = 255,
  parameter int ROM_LIMIT = 65535
) (
  input  logic                i_clk_sys,
  input  logic                i_reset_n,
  input  logic                i_ioctl_download,
  input  logic                i_ioctl_wr,
  input  logic [24:0]         i_ioctl_addr,
  input  logic [7:0]          i_ioctl_dout,
  input  logic [7:0]          i_ioctl_index,
  output logic [ROM_AW-1:0]   o_dn_addr,
  output logic [7:0]          o_dn_data,
  output logic                o_dn_wr,
  output logic [NUM_MODS-1:0] o_mod_sel,
  output logic [63:0]         o_sw_bank,
  output logic                o_cfg_valid,
  output logic                o_core_reset
);

  logic                w_rom_hit;
  logic                w_mod_hit;
  logic                w_dip_hit;
  logic [2:0]          w_dip_sel;
  logic [NUM_MODS-1:0] w_mod_onehot;

  logic                r_dn_wr;
  logic [ROM_AW-1:0]   r_dn_addr;
  logic [7:0]          r_dn_data;
  logic [7:0]          r_mod;
  logic                r_mod_rcvd;
  logic [NUM_MODS-1:0] r_mod_sel;
  logic [63:0]         r_sw_bank;
  logic [7:0]          r_mask;
  logic                r_cfg_valid;

  assign w_rom_hit = i_ioctl_wr && (i_ioctl_index == IDX_ROM) && (i_ioctl_addr <= 25'(ROM_LIMIT));
  assign w_mod_hit = i_ioctl_wr && (i_ioctl_index == IDX_MOD);
  assign w_dip_hit = i_ioctl_wr && (i_ioctl_index == IDX_DIP) && (i_ioctl_addr[24:3] == '0);
  assign w_dip_sel = i_ioctl_addr[2:0];

  // Out-of-range mod values select no game rather than aliasing onto a real one.
  always_comb begin
    w_mod_onehot = '0;
    if (32'(r_mod) < 32'(NUM_MODS)) w_mod_onehot = NUM_MODS'(1) << r_mod;
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dn_wr     <= 1'b0;
      r_dn_addr   <= '0;
      r_dn_data   <= '0;
      r_mod       <= '0;
      r_mod_rcvd  <= 1'b0;
      r_mod_sel   <= NUM_MODS'(1);
      r_sw_bank   <= '1;
      r_mask      <= '0;
      r_cfg_valid <= 1'b0;
    end else begin
      r_dn_wr <= w_rom_hit;
      if (w_rom_hit) begin
        r_dn_addr <= i_ioctl_addr[ROM_AW-1:0];
        r_dn_data <= i_ioctl_dout;
      end
      if (w_mod_hit) begin
        r_mod      <= i_ioctl_dout;
        r_mod_rcvd <= 1'b1;
      end
      r_mod_sel <= w_mod_onehot;
      if (w_dip_hit) begin
        r_sw_bank[{w_dip_sel, 3'b000} +: 8] <= i_ioctl_dout;
        r_mask[w_dip_sel]                   <= 1'b1;
      end
      if (r_mod_rcvd && (&r_mask)) r_cfg_valid <= 1'b1;
    end
  end

  cfg_reset_stretch #(
    .RST_HOLD (RST_HOLD)
  ) u_reset_stretch (
    .i_clk        (i_clk_sys),
    .i_rst_n      (i_reset_n),
    .i_download   (i_ioctl_download),
    .o_core_reset (o_core_reset)
  );

  assign o_dn_wr     = r_dn_wr;
  assign o_dn_addr   = r_dn_addr;
  assign o_dn_data   = r_dn_data;
  assign o_mod_sel   = r_mod_sel;
  assign o_sw_bank   = r_sw_bank;
  assign o_cfg_valid = r_cfg_valid;

endmodule
